vga_timing: RTL and testbench

- Raster timing generator for the VGA text path. Sits directly upstream of the pixel data reader.
- Produces the newline, line and advance controls that the pixel reader consumes.
- Takes the reader's 12-bit pixel back, blanks it, and registers it with hsync/vsync to drive the DAC pins.
- Default timing: 640x480@60 from a 25 MHz clock. Text raster is 240 lines with each line shown twice, and 8-pixel glyphs doubled to 16 px wide.

---
 rtl/vga_timing_if.sv | 25 ++
 rtl/vga_timing.sv | 111 +++++++++++
 tb/tb_vga_timing.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// vga_timing_if: raster-control and DAC-pin bundle between vga_timing and its
// neighbours (pixel reader upstream of pixel, DAC downstream of rgb/syncs).
interface vga_timing_if;
  logic        newline;
  logic [7:0]  line;
  logic        advance;
  logic [11:0] pixel;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        hsync;
  logic        vsync;

  // Timing generator side
  modport master (
    output newline, line, advance, red, green, blue, hsync, vsync,
    input  pixel
  );

  // Reader / DAC side
  modport slave (
    input  newline, line, advance, red, green, blue, hsync, vsync,
    output pixel
  );
endinterface

// File: rtl/vga_timing.sv
// vga_timing: VGA raster timing generator (default 640x480@60, 25 MHz pixel clock).
// Drives newline/line/advance for the pixel reader, then blanks the returned
// pixel and registers it with active-low hsync/vsync for the DAC pins.
// Optional build macro: VGA_BORDER_EN forces 12'hF00 on the outermost active
// rows/columns; left undefined, active pixels pass straight through.
module vga_timing #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned PREFETCH = 4
) (
  input  logic         clk,
  input  logic         reset,
  vga_timing_if.master bus
);

  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] H_NL    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - PREFETCH);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0]  hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;

  logic        active;
  logic [9:0]  nv;
  logic        newline;
  logic [7:0]  line;
  logic        hs_raw;
  logic        vs_raw;

  // Next raster position: hcount wraps each line, vcount steps on that wrap
  always_comb begin
    hcount_d = (hcount_q == H_LAST) ? '0 : hcount_q + 10'd1;
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
    end
  end

  // Reader controls and raw syncs, all decoded from the current counters
  always_comb begin
    active  = (hcount_q < H_ACT) && (vcount_q < V_ACT);
    nv      = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
    newline = (hcount_q == H_NL) && (nv < V_ACT);
    line    = newline ? nv[8:1] : '0;
    hs_raw  = !((hcount_q >= HS_BEG) && (hcount_q <= HS_END));
    vs_raw  = !((vcount_q >= VS_BEG) && (vcount_q <= VS_END));
  end

  // Output stage inputs: blanked (optionally bordered) pixel plus syncs
  always_comb begin
    rgb_d   = '0;
    hsync_d = hs_raw;
    vsync_d = vs_raw;
    if (active) begin
`ifdef VGA_BORDER_EN
      if ((hcount_q == '0) || (hcount_q == H_ACT - 10'd1) ||
          (vcount_q == '0) || (vcount_q == V_ACT - 10'd1)) begin
        rgb_d = 12'hF00;
      end else begin
        rgb_d = bus.pixel;
      end
`else
      rgb_d = bus.pixel;
`endif
    end
  end

  // Counter and pin registers; reset parks at (0,0) with syncs deasserted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount_q <= '0;
      vcount_q <= '0;
      rgb_q    <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      rgb_q    <= rgb_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
    end
  end

  // Counters idle at (0,0) during reset, which decodes as active; advance is
  // gated so the reader is not clocked while reset is held.
  assign bus.advance = active & ~reset;
  assign bus.newline = newline;
  assign bus.line    = line;
  assign bus.red     = rgb_q[11:8];
  assign bus.green   = rgb_q[7:4];
  assign bus.blue    = rgb_q[3:0];
  assign bus.hsync   = hsync_q;
  assign bus.vsync   = vsync_q;

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed bench for vga_timing on a shrunken raster
// (16+2+4+3 = 25 clocks/line, 8+1+2+2 = 13 lines/frame, 325 clocks/frame).
module tb_vga_timing;

  logic clk = 1'b0;
  logic reset;
  vga_timing_if bus ();

  always #5 clk = ~clk;

  vga_timing #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2),
    .PREFETCH(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [11:0] rgb;
  assign rgb = {bus.red, bus.green, bus.blue};

`ifdef VGA_BORDER_EN
  localparam int EXP_RED = 44;
  localparam int EXP_BLU = 84;
  localparam int EXP_EDGE = 'hF00;
`else
  localparam int EXP_RED = 0;
  localparam int EXP_BLU = 128;
  localparam int EXP_EDGE = 'h00F;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int th, tv;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: sample point moves to #1 after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    th++;
    if (th == 25) begin
      th = 0;
      tv++;
      if (tv == 13) tv = 0;
    end
  endtask

  initial begin
    int exp_line [8];
    int n_adv, adv_err, n_nl, line_err, nl_idx;
    int n_hs, n_vs, n_hfall, n_vfall, n_col, rgb_err, n_red, n_blu;
    logic hs_last, vs_last, act, prev_act;

    exp_line = '{0, 1, 1, 2, 2, 3, 3, 0};
    n_adv = 0; adv_err = 0; n_nl = 0; line_err = 0; nl_idx = 0;
    n_hs = 0; n_vs = 0; n_hfall = 0; n_vfall = 0; n_col = 0; rgb_err = 0;
    n_red = 0; n_blu = 0;
    hs_last = 1'b1; vs_last = 1'b1; prev_act = 1'b0;

    reset = 1'b1;
    bus.pixel = 12'hABC;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", int'(rgb), 0);
    chk("rst_hs", int'(bus.hsync), 1);
    chk("rst_vs", int'(bus.vsync), 1);
    chk("rst_nl", int'(bus.newline), 0);
    chk("rst_adv", int'(bus.advance), 0);

    @(negedge clk);
    reset = 1'b0;
    th = 0; tv = 0;
    #1;

    // Two full frames from reset release
    for (int k = 0; k < 650; k++) begin
      if (k > 0) tick();
      act = (th < 16) && (tv < 8);
      if (bus.advance) n_adv++;
      if (bus.advance != act) adv_err++;
      if (bus.newline) begin
        n_nl++;
        chk("nl_hpos", th, 21);
        chk("nl_line", int'(bus.line), exp_line[nl_idx % 8]);
        nl_idx++;
      end else if (bus.line != 8'd0) begin
        line_err++;
      end
      if (!bus.hsync) n_hs++;
      if (!bus.vsync) n_vs++;
      if (!bus.hsync && hs_last) n_hfall++;
      if (!bus.vsync && vs_last) n_vfall++;
      hs_last = bus.hsync;
      vs_last = bus.vsync;
      if (rgb == 12'hABC) n_col++;
      if (rgb != (prev_act ? 12'hABC : 12'h000)) rgb_err++;
      if (k == 0) chk("rgb_first_clk", int'(rgb), 0);
      if (k == 1) chk("rgb_after_h0", int'(rgb), 'hABC);
      if (k == 16) chk("adv_h16", int'(bus.advance), 0);
      if (k == 17) chk("rgb_after_h16", int'(rgb), 0);
      prev_act = act;
    end
    chk("adv_count", n_adv, 256);
    chk("adv_pattern", adv_err, 0);
    chk("nl_count", n_nl, 16);
    chk("line_idle", line_err, 0);
    chk("hs_low_clks", n_hs, 104);
    chk("hs_pulses", n_hfall, 26);
    chk("vs_low_clks", n_vs, 100);
    chk("vs_pulses", n_vfall, 2);
    chk("rgb_colored", n_col, 256);
    chk("rgb_align", rgb_err, 0);

    // Run into the vsync region mid hsync pulse, then reset asynchronously
    for (int g = 0; g < 400 && !(tv == 9 && th == 20); g++) tick();
    chk("pre_rst_pos", th + 100 * tv, 920);
    chk("pre_rst_hs", int'(bus.hsync), 0);
    chk("pre_rst_vs", int'(bus.vsync), 0);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_hs", int'(bus.hsync), 1);
    chk("mid_rst_vs", int'(bus.vsync), 1);
    chk("mid_rst_rgb", int'(rgb), 0);
    chk("mid_rst_nl", int'(bus.newline), 0);
    chk("mid_rst_adv", int'(bus.advance), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.pixel = 12'h00F;
    th = 0; tv = 0;
    #1;
    chk("resume_adv", int'(bus.advance), 1);

    // One frame with a blue pixel: border handling and restart timing
    for (int k = 0; k < 325; k++) begin
      if (k > 0) tick();
      if (rgb == 12'hF00) n_red++;
      if (rgb == 12'h00F) n_blu++;
      if (k == 21) begin
        chk("resume_nl", int'(bus.newline), 1);
        chk("resume_line", int'(bus.line), 0);
      end
      if (k == 26) chk("edge_h0_v1", int'(rgb), EXP_EDGE);
      if (k == 32) chk("inner_h6_v1", int'(rgb), 'h00F);
      if (k == 41) chk("edge_h15_v1", int'(rgb), EXP_EDGE);
      if (k == 181) chk("edge_h5_v7", int'(rgb), EXP_EDGE);
      if (k == 201) chk("blank_v8", int'(rgb), 0);
    end
    chk("border_red", n_red, EXP_RED);
    chk("border_blue", n_blu, EXP_BLU);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
